bin2bcd_seq: RTL and testbench



---
 rtl/bin2bcd_pkg.sv | 18 +
 rtl/bcd_digit_adj.sv | 9 +
 rtl/bin2bcd_seq.sv | 102 ++++++++++
 tb/tb_bin2bcd_seq.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared constants and types for the sequential binary-to-BCD converter.
`timescale 1ns/1ps
package bin2bcd_pkg;
   localparam int BIN_W  = 27;
   localparam int DIGITS = 8;
   localparam int BCD_W  = 4 * DIGITS;
   localparam int CNT_W  = $clog2(BIN_W);

   localparam logic [BIN_W-1:0]  BCD_MAX   = BIN_W'(10 ** DIGITS - 1);
   localparam logic [BCD_W-1:0]  BCD_NINES = {DIGITS{4'h9}};
   localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BIN_W - 1);

   typedef enum logic {
      ST_IDLE,
      ST_SHIFT
   } state_t;
endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD nibble of the double-dabble step: add 3 when the digit is 5 or more.
`timescale 1ns/1ps
module bcd_digit_adj (
   input  logic [3:0] digit,
   output logic [3:0] adjusted
);
   // Inputs never exceed 9 here, so the sum fits in 4 bits.
   assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;
endmodule

// File: rtl/bin2bcd_seq.sv
// Shift-and-add-3 binary to packed BCD converter, one input bit per clock,
// with leading-zero blank mask and saturation on out-of-range input.
`timescale 1ns/1ps
module bin2bcd_seq
   import bin2bcd_pkg::*;
(
   input  logic              iCLK,
   input  logic              iRST,
   input  logic              iStart,
   input  logic [BIN_W-1:0]  iBin,
   output logic              oBusy,
   output logic              oDone,
   output logic [BCD_W-1:0]  oBcd,
   output logic [DIGITS-1:0] oBlank,
   output logic              oOvf
);
   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               ovf_pend;
   logic [BCD_W-1:0]   bcd_acc;
   logic [BIN_W-1:0]   bin_sr;
   logic [BCD_W-1:0]   acc_adj;
   logic [BCD_W-1:0]   acc_next;
   logic               carry_unused;
   logic [DIGITS-1:0]  blank_next;
   logic               zeros_above;

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit    (bcd_acc[4*g +: 4]),
         .adjusted (acc_adj[4*g +: 4])
      );
   end

   // The adjusted top bit only leaves the accumulator on overflow, which saturates anyway.
   assign {carry_unused, acc_next} = {acc_adj, bin_sr[BIN_W-1]};

   always_comb begin
      blank_next  = '0;
      zeros_above = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zeros_above   = zeros_above && (acc_next[4*i +: 4] == 4'd0);
         blank_next[i] = zeros_above;
      end
   end

   always_ff @(posedge iCLK) begin
      if (state == ST_IDLE) begin
         if (iStart) begin
            bcd_acc <= '0;
            bin_sr  <= iBin;
         end
      end else begin
         bcd_acc <= acc_next;
         bin_sr  <= {bin_sr[BIN_W-2:0], 1'b0};
      end
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         ovf_pend <= 1'b0;
         oBusy    <= 1'b0;
         oDone    <= 1'b0;
         oBcd     <= '0;
         oBlank   <= BLANK_RST;
         oOvf     <= 1'b0;
      end else begin
         oDone <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (iStart) begin
                  state    <= ST_SHIFT;
                  cnt      <= CNT_LAST;
                  ovf_pend <= (iBin > BCD_MAX);
                  oBusy    <= 1'b1;
               end
            end
            ST_SHIFT: begin
               if (cnt == '0) begin
                  state <= ST_IDLE;
                  oBusy <= 1'b0;
                  oDone <= 1'b1;
                  if (ovf_pend) begin
                     oBcd   <= BCD_NINES;
                     oBlank <= '0;
                     oOvf   <= 1'b1;
                  end else begin
                     oBcd   <= acc_next;
                     oBlank <= blank_next;
                     oOvf   <= 1'b0;
                  end
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: decimal-arithmetic reference model plus directed literals.
`timescale 1ns/1ps
module tb_bin2bcd_seq;
   localparam int LAT = 27;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [26:0] bin = '0;
   logic        busy, done, ovf;
   logic [31:0] bcd;
   logic [7:0]  blank;

   int tests = 0;
   int fails = 0;
   bit checking = 1'b0;

   logic        m_busy = 1'b0;
   logic        m_done = 1'b0;
   logic        m_ovf = 1'b0;
   logic [31:0] m_bcd = '0;
   logic [7:0]  m_blank = 8'hFE;
   logic [26:0] m_val = '0;
   int          m_left = 0;

   bin2bcd_seq dut (
      .iCLK   (clk),
      .iRST   (rst),
      .iStart (start),
      .iBin   (bin),
      .oBusy  (busy),
      .oDone  (done),
      .oBcd   (bcd),
      .oBlank (blank),
      .oOvf   (ovf)
   );

   always #5 clk = ~clk;

   // Decimal digits by division; blanks from the decimal length of the value.
   function automatic void expect_of(input logic [26:0] v, output logic [31:0] b,
                                     output logic [7:0] bl, output logic o);
      int unsigned x;
      int nd;
      b  = '0;
      bl = '0;
      o  = 1'b0;
      if (v > 27'd99999999) begin
         b = 32'h99999999;
         o = 1'b1;
      end else begin
         x = v;
         for (int i = 0; i < 8; i++) begin
            b[4*i +: 4] = 4'(x % 10);
            x = x / 10;
         end
         nd = 1;
         x  = v;
         while (x >= 10) begin
            x  = x / 10;
            nd = nd + 1;
         end
         for (int i = 1; i < 8; i++) bl[i] = (i >= nd);
      end
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference model: a conversion accepted at an edge completes LAT edges later.
   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_bcd   = '0;
            m_blank = 8'hFE;
            m_ovf   = 1'b0;
            m_left  = 0;
         end else begin
            m_done = 1'b0;
            if (m_busy) begin
               m_left--;
               if (m_left == 0) begin
                  m_busy = 1'b0;
                  m_done = 1'b1;
                  expect_of(m_val, m_bcd, m_blank, m_ovf);
               end
            end else if (start) begin
               m_busy = 1'b1;
               m_left = LAT;
               m_val  = bin;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (checking && !rst) begin
            check("cyc_busy", 32'(busy), 32'(m_busy));
            check("cyc_done", 32'(done), 32'(m_done));
            check("cyc_bcd", bcd, m_bcd);
            check("cyc_blank", 32'(blank), 32'(m_blank));
            check("cyc_ovf", 32'(ovf), 32'(m_ovf));
         end
      end
   end

   task automatic pulse_start(input logic [26:0] v);
      start = 1'b1;
      bin   = v;
      @(posedge clk);
      #1;
      start = 1'b0;
      bin   = 27'($urandom);
   endtask

   task automatic wait_done(output int n, output int nb);
      n  = 0;
      nb = busy ? 1 : 0;
      do begin
         @(posedge clk);
         #1;
         n++;
         if (busy) nb++;
      end while (!done && n < 100);
      if (!done) begin
         tests++;
         fails++;
         $display("FAIL done_timeout: no oDone after %0d cycles, required within %0d", n, LAT);
      end
   endtask

   task automatic run(input logic [26:0] v, input logic [31:0] eb, input logic [7:0] ebl,
                      input logic eo, input string name);
      int n, nb;
      pulse_start(v);
      wait_done(n, nb);
      check({name, "_latency"}, 32'(n), 32'(LAT));
      check({name, "_busy_cycles"}, 32'(nb), 32'(LAT));
      check({name, "_bcd"}, bcd, eb);
      check({name, "_blank"}, 32'(blank), 32'(ebl));
      check({name, "_ovf"}, 32'(ovf), 32'(eo));
   endtask

   initial begin
      logic [31:0] eb;
      logic [7:0]  ebl;
      logic        eo;
      logic [26:0] v;
      int          n, nb, ndone;

      expect_of(27'd305, eb, ebl, eo);
      check("model_305_bcd", eb, 32'h00000305);
      check("model_305_blank", 32'(ebl), 32'h000000F8);
      expect_of(27'h5F5E100, eb, ebl, eo);
      check("model_ovf_bcd", eb, 32'h99999999);
      check("model_ovf_flag", 32'(eo), 32'd1);

      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_bcd", bcd, 32'h0);
      check("rst_blank", 32'(blank), 32'h000000FE);
      check("rst_ovf", 32'(ovf), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      rst = 1'b0;
      checking = 1'b1;
      @(posedge clk);
      #1;

      run(27'd0, 32'h00000000, 8'b11111110, 1'b0, "zero");
      repeat (2) @(posedge clk);
      #1;
      run(27'd12345678, 32'h12345678, 8'h00, 1'b0, "d12345678");
      run(27'd99999999, 32'h99999999, 8'h00, 1'b0, "max");
      run(27'h5F5E100, 32'h99999999, 8'h00, 1'b1, "ovf");
      run(27'd305, 32'h00000305, 8'b11111000, 1'b0, "d305");
      run(27'd1000000, 32'h01000000, 8'b10000000, 1'b0, "d1e6");
      run(27'd4096, 32'h00004096, 8'b11110000, 1'b0, "b2b_4096");

      pulse_start(27'd12345678);
      repeat (5) @(posedge clk);
      #1;
      start = 1'b1;
      bin   = 27'd7;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(n, nb);
      check("ignored_latency", 32'(n), 32'd21);
      check("ignored_bcd", bcd, 32'h12345678);
      ndone = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done) ndone++;
      end
      check("ignored_extra_done", 32'(ndone), 32'd0);

      pulse_start(27'd12345678);
      repeat (10) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("midrst_bcd", bcd, 32'h0);
      check("midrst_blank", 32'(blank), 32'h000000FE);
      check("midrst_ovf", 32'(ovf), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b0;
      ndone = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done) ndone++;
      end
      check("midrst_no_done", 32'(ndone), 32'd0);
      run(27'd42, 32'h00000042, 8'b11111100, 1'b0, "after_rst_42");

      for (int r = 0; r < 25; r++) begin
         case ($urandom_range(0, 3))
            0:       v = 27'($urandom_range(0, 134217727));
            1:       v = 27'($urandom_range(0, 999));
            2:       v = 27'($urandom_range(99999990, 100000010));
            default: v = 27'($urandom_range(0, 99999999));
         endcase
         expect_of(v, eb, ebl, eo);
         pulse_start(v);
         wait_done(n, nb);
         check("rand_latency", 32'(n), 32'(LAT));
         check("rand_bcd", bcd, eb);
         check("rand_blank", 32'(blank), 32'(ebl));
         check("rand_ovf", 32'(ovf), 32'(eo));
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 3)) begin
               @(posedge clk);
               #1;
            end
         end
      end

      repeat (3) @(posedge clk);
      #1;
      checking = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
